// File: rtl/fpdiv_ctrl.sv
// fpdiv_ctrl: Goldschmidt divider sequencer driving fpdiv register enables and multiplier selects.
module fpdiv_ctrl #(
  parameter int ITER = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       en_a,
  output logic       en_b,
  output logic       en_rem,
  output logic [1:0] sel_mux3,
  output logic [1:0] sel_mux4,
  output logic       busy,
  output logic       done
);
  typedef enum logic [2:0] {IDLE, INIT_A, INIT_B, IT_A, IT_B, REM, DONE} state_t;
  localparam logic [2:0] LAST = 3'(ITER - 1);
  state_t state, nxt;
  logic [2:0] cnt;
  logic [8:0] dec;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? INIT_A : IDLE;
      INIT_A:  nxt = INIT_B;
      INIT_B:  nxt = IT_A;
      IT_A:    nxt = IT_B;
      IT_B:    nxt = (cnt == LAST) ? REM : IT_A;
      REM:     nxt = DONE;
      DONE:    nxt = start ? INIT_A : IDLE;
      default: nxt = IDLE;
    endcase
  end
  // Outputs are decoded from the state being entered so they register alongside it.
  always_comb begin
    dec = '0;
    case (nxt)
      INIT_A:  dec = 9'b1_0_100_00_00;
      INIT_B:  dec = 9'b1_0_010_00_01;
      IT_A:    dec = 9'b1_0_100_01_10;
      IT_B:    dec = 9'b1_0_010_01_11;
      REM:     dec = 9'b1_0_001_10_10;
      DONE:    dec = 9'b0_1_000_00_00;
      default: dec = '0;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      {busy, done, en_a, en_b, en_rem, sel_mux3, sel_mux4} <= '0;
    end else begin
      state <= nxt;
      cnt <= (state == INIT_B) ? 3'd0 : (state == IT_B) ? cnt + 3'd1 : cnt;
      {busy, done, en_a, en_b, en_rem, sel_mux3, sel_mux4} <= dec;
    end
  end
endmodule

// File: tb/tb_fpdiv_ctrl.sv
// tb_fpdiv_ctrl: directed vector bench for fpdiv_ctrl at ITER=3, plus latency sweeps at ITER=1 and 7.
module tb_fpdiv_ctrl;
  logic clk = 0;
  logic reset = 0;
  logic [2:0] st = '0;
  logic ea [3], eb [3], er [3], bz [3], dn [3];
  logic [1:0] s3 [3], s4 [3];
  logic [8:0] o [3];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fpdiv_ctrl #(.ITER(3)) u_i3 (.clk(clk), .reset(reset), .start(st[0]), .en_a(ea[0]), .en_b(eb[0]),
    .en_rem(er[0]), .sel_mux3(s3[0]), .sel_mux4(s4[0]), .busy(bz[0]), .done(dn[0]));
  fpdiv_ctrl #(.ITER(1)) u_i1 (.clk(clk), .reset(reset), .start(st[1]), .en_a(ea[1]), .en_b(eb[1]),
    .en_rem(er[1]), .sel_mux3(s3[1]), .sel_mux4(s4[1]), .busy(bz[1]), .done(dn[1]));
  fpdiv_ctrl #(.ITER(7)) u_i7 (.clk(clk), .reset(reset), .start(st[2]), .en_a(ea[2]), .en_b(eb[2]),
    .en_rem(er[2]), .sel_mux3(s3[2]), .sel_mux4(s4[2]), .busy(bz[2]), .done(dn[2]));

  for (genvar g = 0; g < 3; g++) begin : g_pack
    assign o[g] = {bz[g], dn[g], ea[g], eb[g], er[g], s3[g], s4[g]};
  end

  // {busy, done, en_a, en_b, en_rem, sel_mux3, sel_mux4}
  localparam logic [8:0] O_IDLE = 9'b0_0_000_00_00;
  localparam logic [8:0] O_IA   = 9'b1_0_100_00_00;
  localparam logic [8:0] O_IB   = 9'b1_0_010_00_01;
  localparam logic [8:0] O_ITA  = 9'b1_0_100_01_10;
  localparam logic [8:0] O_ITB  = 9'b1_0_010_01_11;
  localparam logic [8:0] O_REM  = 9'b1_0_001_10_10;
  localparam logic [8:0] O_DN   = 9'b0_1_000_00_00;

  typedef struct packed {
    logic       st;
    logic [8:0] exp;
  } vec_t;
  vec_t tab[$];

  task automatic chk(input string name, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b expected=%b", name, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic run_lat(input int d, input int lat, input int pairs);
    int n, p, bad;
    bit got;
    logic [8:0] v;
    n = 0; p = 0; bad = 0; got = 0;
    @(negedge clk) st[d] = 1;
    @(posedge clk);
    #1 st[d] = 0;
    n = 1;
    while (!got && n < 60) begin
      v = o[d];
      if ($countones(v[6:4]) > 1) bad++;
      if (v[6] && v[3:2] == 2'd1) p++;
      if (v[7]) got = 1;
      else begin
        @(posedge clk);
        #1 n++;
      end
    end
    chk_int($sformatf("latency_i%0d", d), n, lat);
    chk_int($sformatf("pairs_i%0d", d), p, pairs);
    chk_int($sformatf("onehot_i%0d", d), bad, 0);
  endtask

  initial begin
    logic [8:0] seq [10];
    seq = '{O_IA, O_IB, O_ITA, O_ITB, O_ITA, O_ITB, O_ITA, O_ITB, O_REM, O_DN};
    for (int k = 0; k < 10; k++) tab.push_back('{k == 0, seq[k]});
    tab.push_back('{1'b0, O_IDLE});
    for (int k = 0; k < 10; k++) tab.push_back('{k == 0 || k == 3 || k == 7, seq[k]});
    tab.push_back('{1'b0, O_IDLE});
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 10; k++) tab.push_back('{1'b1, seq[k]});
    tab.push_back('{1'b0, O_IDLE});

    // Reset held with start toggling, then released with start low.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk) st = ~st;
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) chk($sformatf("in_reset_%0d_%0d", k, d), o[d], O_IDLE);
    end
    @(negedge clk) begin st = '0; reset = 1; end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) chk($sformatf("post_reset_%0d_%0d", k, d), o[d], O_IDLE);
    end

    // Single, start-while-busy and back-to-back sequences.
    for (int i = 0; i < tab.size(); i++) begin
      @(negedge clk) st[0] = tab[i].st;
      @(posedge clk);
      #1 chk($sformatf("vec%0d", i), o[0], tab[i].exp);
    end

    // Reset during IT_B of the second iteration.
    @(negedge clk) st[0] = 1;
    @(posedge clk);
    #1 st[0] = 0;
    repeat (5) @(posedge clk);
    #1 chk("mid_itb", o[0], O_ITB);
    #1 reset = 0;
    #1 chk("mid_async", o[0], O_IDLE);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 chk($sformatf("mid_hold%0d", k), o[0], O_IDLE);
    end
    @(negedge clk) reset = 1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1 chk($sformatf("mid_nodone%0d", k), o[0], O_IDLE);
    end
    run_lat(0, 10, 3);

    run_lat(1, 6, 1);
    run_lat(2, 18, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fpdiv_ctrl.md
# fpdiv_ctrl

Sequencer for the Goldschmidt single-precision divider datapath `fpdiv`. It accepts a start request and drives the datapath's register enables (`en_a`, `en_b`, `en_rem`) and multiplier operand selects (`sel_mux3`, `sel_mux4`) through these phases: initial approximation, `ITER` refinement iterations, and the remainder multiply. It then pulses `done` when `final_ans` is valid. It instantiates next to `fpdiv` and is the only source of that datapath's control inputs.

## Interface
- `ITER`, default 3, number of Goldschmidt refinement iterations; legal range 1..7.
- `clk`  input  1  clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `start`  input  1  request a division; operands on `inputNum`/`inputDenom` must be stable from the accepting edge until `done`.
- `en_a`  output  1  load datapath register A (quotient estimate).
- `en_b`  output  1  load datapath registers B and C (denominator estimate and its ones'-complement factor).
- `en_rem`  output  1  load datapath remainder register.
- `sel_mux3`  output  2  multiplier operand 1 select: 0 = initial approx 0.75, 1 = reg C, 2 = denominator; 3 is never driven.
- `sel_mux4`  output  2  multiplier operand 2 select: 0 = numerator, 1 = denominator, 2 = reg A, 3 = reg B.
- `busy`  output  1  sequence in progress.
- `done`  output  1  one-cycle pulse; datapath result valid.

## Operation
- States: IDLE, INIT_A, INIT_B, IT_A, IT_B, REM, DONE. All outputs are a Moore decode of the state register only.
- Reset (asynchronous, `reset`=0): state=IDLE, iteration counter=0. Every output is 0 while reset is held and in IDLE.
- IDLE: all enables 0, selects 0, `busy`=0, `done`=0. `start`=1 moves to INIT_A.
- INIT_A: sel3=0, sel4=0, `en_a`=1, so A <= 0.75·N. Next state is INIT_B.
- INIT_B: sel3=0, sel4=1, `en_b`=1, so B <= 0.75·D and C <= OC(0.75·D). Counter is cleared. Next state is IT_A.
- IT_A: sel3=1, sel4=2, `en_a`=1, so A <= C·A. Next state is IT_B.
- IT_B: sel3=1, sel4=3, `en_b`=1, so B <= C·B and C <= OC(C·B). Counter increments.
  - If the counter reaches `ITER`-1 before incrementing, go to REM.
  - Otherwise go to IT_A.
- REM: sel3=2, sel4=2, `en_rem`=1, so remainder register <= D·A. Next state is DONE.
- DONE: `done`=1, `busy`=0, all enables 0.
  - `start`=1 goes directly to INIT_A (back-to-back operation).
  - Otherwise go to IDLE.
- `busy`=1 exactly in INIT_A, INIT_B, IT_A, IT_B and REM.
- `start` is ignored while `busy`=1. No queueing; the request is dropped.
- At most one of `en_a`, `en_b`, `en_rem` is high in any cycle.
- After DONE, all enables stay 0 until the next accepted start. The datapath registers therefore hold, and `final_ans` stays valid indefinitely.
- Iteration counter width is 3 bits. It never wraps, because `ITER` ≤ 7.
- Reset asserted mid-sequence: immediate return to IDLE with all outputs 0. The partial datapath contents are don't-care, and no `done` is issued.

## Timing
- Let start be sampled high at edge 0 in IDLE or DONE.
  - INIT_A occupies cycle 1 (edge 0 to edge 1).
  - INIT_B occupies cycle 2.
  - IT_A/IT_B pairs occupy cycles 3 .. 2+2·`ITER`.
  - REM occupies cycle 3+2·`ITER`.
  - DONE occupies cycle 4+2·`ITER`.
- Latency from the start edge to `done` high is 2·`ITER`+4 cycles. For `ITER`=3 that is 10, with `done` high in cycle 10.
- Throughput with back-to-back starts is one result per 2·`ITER`+4 cycles.
- Each enable is high for exactly one cycle per write. The datapath register captures at the edge ending that cycle.
- Selects are valid for the whole cycle in which the matching enable is high.

## Test plan
- Reset: hold `reset`=0 with `start`=1 toggling, then release and keep `start`=0. All outputs must be 0 and the state must stay IDLE.
- Single divide with `ITER`=3, operands 0x40400000 / 0x40000000:
  - Sequence must be {sel3,sel4,en} = (0,0,a), (0,1,b), then (1,2,a),(1,3,b) three times, then (2,2,rem).
  - `done` must pulse in cycle 10.
  - `final_ans` must be 0x3FC00000 (1.5) and stay there for 20 idle cycles.
- Back-to-back: hold `start`=1 continuously.
  - `done` must pulse every 10 cycles.
  - INIT_A must immediately follow each DONE, with no IDLE cycle in between.
  - Results must match the reference model.
- Start while busy: pulse `start` in cycles 3 and 7 of a sequence. The sequence and the single `done` at cycle 10 must be unchanged.
- Mid-sequence reset: assert `reset`=0 during IT_B of iteration 2, then release and start again. There must be no `done` for the aborted operation, and the new operation must complete in 10 cycles.
- Parameter sweep `ITER`=1 and 7:
  - `done` latency must be 6 and 18 cycles respectively.
  - The IT_A/IT_B pair count must equal `ITER`.
  - One-hot enable exclusivity must hold in every cycle.
